// File: rtl/window_sched_pkg.sv
// Shared types and constants for the Hanning window frame scheduler.
// Imported by the scheduler top and its ping-pong buffer.
package window_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    WAIT_FFT
  } sched_state_e;

  localparam int FRAMES_SENT_WIDTH = 16;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/frame_pingpong_buffer.sv
// Two-frame sample store: one write port, one registered read port.
// Address is {bank, index}.
import window_sched_pkg::*;

module frame_pingpong_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_in,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_bank,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[{wr_bank, wr_idx}] <= wr_data;
    end
    rd_data <= mem[{rd_bank, rd_idx}];
  end

endmodule

// File: rtl/window_frame_scheduler.sv
// Per-frame sequencer for the window/FFT chain: buffers audio into
// two banks and replays each full frame as one contiguous burst.
import window_sched_pkg::*;

module window_frame_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_SIZE = 4096,
  parameter int ADDR_WIDTH = $clog2(FRAME_SIZE)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [DATA_WIDTH-1:0]        in_sample,
  input  logic                         audio_sample_valid,
  input  logic                         fft_idle,
  input  logic                         fft_done,
  output logic [DATA_WIDTH-1:0]        win_sample,
  output logic [ADDR_WIDTH-1:0]        win_coeff_addr,
  output logic                         win_valid,
  output logic                         win_first,
  output logic                         win_last,
  output logic                         frame_overflow,
  output logic [FRAMES_SENT_WIDTH-1:0] frames_sent
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(FRAME_SIZE - 1);

  sched_state_e state_q, state_d;

  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q;
  logic [ADDR_WIDTH-1:0] wr_idx_q;
  logic                  rd_bank_q;
  logic                  oldest_bank;
  logic [ADDR_WIDTH-1:0] rd_idx_q;
  logic [ADDR_WIDTH-1:0] data_idx_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_ok, wr_wrap;
  logic                  start, issue, streaming;

  assign wr_ok     = audio_sample_valid && !full_q[wr_bank_q];
  assign wr_wrap   = wr_ok && (wr_idx_q == LAST_IDX);
  assign start     = (state_q == IDLE) && (|full_q) && fft_idle;
  assign streaming = (state_q == STREAM);
  assign issue     = (state_q == PRIME) || streaming;

  // With both banks full the write pointer sits on the older one.
  assign oldest_bank = (&full_q) ? wr_bank_q :
                       (full_q[BANK_B] ? BANK_B : BANK_A);

  always_comb begin
    full_d = full_q;
    if (win_last) full_d[rd_bank_q] = 1'b0;
    if (wr_wrap)  full_d[wr_bank_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = PRIME;
      PRIME:    state_d = STREAM;
      STREAM:   if (data_idx_q == LAST_IDX) state_d = WAIT_FFT;
      WAIT_FFT: if (fft_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      full_q         <= '0;
      wr_bank_q      <= BANK_A;
      wr_idx_q       <= '0;
      rd_bank_q      <= BANK_A;
      rd_idx_q       <= '0;
      data_idx_q     <= '0;
      win_sample     <= '0;
      win_coeff_addr <= '0;
      win_valid      <= 1'b0;
      win_first      <= 1'b0;
      win_last       <= 1'b0;
      frame_overflow <= 1'b0;
      frames_sent    <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      if (audio_sample_valid) begin
        if (full_q[wr_bank_q]) begin
          frame_overflow <= 1'b1;
        end else if (wr_wrap) begin
          wr_idx_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_idx_q <= wr_idx_q + 1'b1;
        end
      end
      if (start) begin
        rd_bank_q <= oldest_bank;
        rd_idx_q  <= '0;
      end else if (issue) begin
        rd_idx_q   <= rd_idx_q + 1'b1;
        data_idx_q <= rd_idx_q;
      end
      // rd_data lags the issued index by one cycle.
      win_valid <= streaming;
      win_first <= streaming && (data_idx_q == '0);
      win_last  <= streaming && (data_idx_q == LAST_IDX);
      if (streaming) begin
        win_sample     <= rd_data;
        win_coeff_addr <= data_idx_q;
      end
      if (win_last) frames_sent <= frames_sent + 1'b1;
    end
  end

  frame_pingpong_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_buf (
    .clk_in (clk_in),
    .wr_en  (wr_ok),
    .wr_bank(wr_bank_q),
    .wr_idx (wr_idx_q),
    .wr_data(in_sample),
    .rd_bank(rd_bank_q),
    .rd_idx (rd_idx_q),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_window_frame_scheduler.sv
// Bench for window_frame_scheduler with FRAME_SIZE=8: frame-queue model
// checked every cycle plus literal burst contents per scenario.
module tb_window_frame_scheduler;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [DW-1:0] in_sample = '0;
  logic          audio_sample_valid = 1'b0;
  logic          fft_idle = 1'b0;
  logic          fft_done = 1'b0;
  logic [DW-1:0] win_sample;
  logic [AW-1:0] win_coeff_addr;
  logic          win_valid, win_first, win_last;
  logic          frame_overflow;
  logic [15:0]   frames_sent;

  always #5 clk_in = ~clk_in;

  window_frame_scheduler #(
    .DATA_WIDTH(DW),
    .FRAME_SIZE(N),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .in_sample         (in_sample),
    .audio_sample_valid(audio_sample_valid),
    .fft_idle          (fft_idle),
    .fft_done          (fft_done),
    .win_sample        (win_sample),
    .win_coeff_addr    (win_coeff_addr),
    .win_valid         (win_valid),
    .win_first         (win_first),
    .win_last          (win_last),
    .frame_overflow    (frame_overflow),
    .frames_sent       (frames_sent)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: completed frames queue (oldest first) plus the partial frame.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] part[$];
  int            phase = 0;
  int            n = 0;
  int            t0 = 0;
  logic          exp_valid = 0, exp_first = 0, exp_last = 0, exp_ovf = 0;
  logic [DW-1:0] exp_sample = '0;
  logic [AW-1:0] exp_addr = '0;
  int            exp_sent = 0;

  always @(posedge clk_in) begin : model
    int nfull, k, j;
    n++;
    if (rst_in) begin
      fq.delete();
      part.delete();
      phase = 0;
      exp_valid = 0; exp_first = 0; exp_last = 0; exp_ovf = 0;
      exp_sample = '0; exp_addr = '0; exp_sent = 0;
    end else begin
      nfull = fq.size() / N;
      if (audio_sample_valid) begin
        if (nfull == 2) exp_ovf = 1;
        else begin
          part.push_back(in_sample);
          if (part.size() == N) begin
            foreach (part[i]) fq.push_back(part[i]);
            part.delete();
          end
        end
      end
      exp_valid = 0; exp_first = 0; exp_last = 0;
      case (phase)
        0: if (nfull > 0 && fft_idle) begin
          phase = 1;
          t0 = n;
        end
        1: begin
          k = n - t0;
          if (k >= 2) begin
            j = k - 2;
            exp_valid  = 1;
            exp_sample = fq[j];
            exp_addr   = AW'(j);
            exp_first  = (j == 0);
            exp_last   = (j == N - 1);
          end
          if (k == N + 1) phase = 2;
        end
        default: begin
          if (n == t0 + N + 2) begin
            repeat (N) void'(fq.pop_front());
            exp_sent = (exp_sent + 1) % 65536;
          end
          if (fft_done) phase = 0;
        end
      endcase
    end
  end

  logic [DW-1:0] obs[$];

  always @(negedge clk_in) begin
    chk("win_valid", win_valid, exp_valid);
    chk("win_first", win_first, exp_first);
    chk("win_last", win_last, exp_last);
    chk("win_sample", win_sample, exp_sample);
    chk("win_coeff_addr", win_coeff_addr, exp_addr);
    chk("frame_overflow", frame_overflow, exp_ovf);
    chk("frames_sent", frames_sent, exp_sent);
    if (win_valid) obs.push_back(win_sample);
  end

  task automatic check_obs(string nm, int lo1, int hi1, int lo2, int hi2);
    logic [DW-1:0] e[$];
    bit bad;
    for (int v = lo1; v <= hi1; v++) e.push_back(DW'(v));
    for (int v = lo2; v <= hi2; v++) e.push_back(DW'(v));
    bad = (e.size() != obs.size());
    if (!bad) foreach (e[i]) if (e[i] != obs[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got %p expected %p", nm, obs, e);
    end
  endtask

  task automatic do_reset();
    rst_in = 1;
    @(negedge clk_in);
    rst_in = 0;
    obs.delete();
  endtask

  task automatic feed(input int first, input int cnt, input int gap);
    for (int i = 0; i < cnt; i++) begin
      in_sample = DW'(first + i);
      audio_sample_valid = 1;
      @(negedge clk_in);
      audio_sample_valid = 0;
      repeat (gap) @(negedge clk_in);
    end
  endtask

  task automatic pulse_done();
    fft_done = 1;
    @(negedge clk_in);
    fft_done = 0;
  endtask

  task automatic wait_last(string nm);
    int c = 0;
    while (!win_last && c < 60) begin
      @(negedge clk_in);
      c++;
    end
    if (!win_last) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int lat;
    @(negedge clk_in);
    rst_in = 0;

    // basic burst from reset, samples every other cycle
    do_reset();
    fft_idle = 1;
    feed(1, 8, 1);
    wait_last("t1");
    repeat (3) @(negedge clk_in);
    check_obs("t1_burst", 1, 8, 1, 0);
    chk("t1_sent", frames_sent, 1);

    // fft_idle low holds the frame; latency once released
    do_reset();
    fft_idle = 0;
    feed(1, 8, 0);
    repeat (6) @(negedge clk_in);
    chk("t2_held", obs.size(), 0);
    fft_idle = 1;
    lat = 0;
    while (!win_valid && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
    chk("t2_latency", lat, 3);
    wait_last("t2");
    repeat (3) @(negedge clk_in);
    check_obs("t2_burst", 1, 8, 1, 0);

    // ping-pong, second burst waits for fft_done
    do_reset();
    fft_idle = 1;
    feed(1, 16, 0);
    wait_last("t3a");
    repeat (10) @(negedge clk_in);
    check_obs("t3_first", 1, 8, 1, 0);
    pulse_done();
    wait_last("t3b");
    repeat (3) @(negedge clk_in);
    check_obs("t3_both", 1, 16, 1, 0);
    chk("t3_sent", frames_sent, 2);

    // overflow drops sample 17
    do_reset();
    fft_idle = 0;
    feed(1, 17, 0);
    repeat (2) @(negedge clk_in);
    chk("t4_ovf", frame_overflow, 1);
    fft_idle = 1;
    wait_last("t4a");
    repeat (2) @(negedge clk_in);
    pulse_done();
    wait_last("t4b");
    repeat (3) @(negedge clk_in);
    check_obs("t4_bursts", 1, 16, 1, 0);
    chk("t4_sent", frames_sent, 2);

    // reset at burst index 3
    do_reset();
    fft_idle = 1;
    feed(1, 8, 0);
    lat = 0;
    while (!(win_valid && win_coeff_addr == 3) && lat < 30) begin
      @(negedge clk_in);
      lat++;
    end
    chk("t5_reach_idx3", win_coeff_addr, 3);
    rst_in = 1;
    @(negedge clk_in);
    rst_in = 0;
    chk("t5_rst_valid", win_valid, 0);
    chk("t5_rst_sample", win_sample, 0);
    chk("t5_rst_sent", frames_sent, 0);
    obs.delete();
    feed(20, 8, 0);
    wait_last("t5");
    repeat (3) @(negedge clk_in);
    check_obs("t5_burst", 20, 27, 1, 0);
    chk("t5_sent", frames_sent, 1);

    // write in the cycle right after win_last lands in the freed bank
    do_reset();
    fft_idle = 1;
    feed(1, 16, 0);
    wait_last("t6a");
    @(negedge clk_in);
    feed(100, 1, 0);
    chk("t6_no_ovf", frame_overflow, 0);
    pulse_done();
    wait_last("t6b");
    @(negedge clk_in);
    pulse_done();
    feed(101, 7, 0);
    wait_last("t6c");
    repeat (3) @(negedge clk_in);
    check_obs("t6_bursts", 1, 16, 100, 107);
    chk("t6_sent", frames_sent, 3);
    chk("t6_ovf_end", frame_overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
